// File: rtl/cart_mmc1.sv
// ---------------------------------------------------------------------------
// cart_mmc1 : MMC1 (SxROM) cartridge mapper
//
// CPU writes to $8000-$FFFF feed a 5-bit serial loader. Each fifth write
// commits the assembled value to one of four bank registers. The registers
// select banking modes and bank numbers, and they drive the PRG and CHR BRAM
// addresses and the CIRAM mirroring line. The BRAMs are external. Their one
// cycle of read latency is absorbed outside this block.
//
// Ports
//   clk_sys        system clock
//   rst            synchronous reset, active high; rst_out mirrors it
//   prg_nce_in     PRG chip enable (active low, CPU $8000-$FFFF)
//   prg_a_in       CPU address [14:0]
//   prg_r_nw_in    CPU read/write (1 = read)
//   prg_d_in       CPU write data
//   prg_d_out      PRG read data to CPU (zero while not selected)
//   prg_rom_addr   banked PRG BRAM address
//   prg_rom_q      PRG BRAM data
//   chr_a_in       PPU address [13:0]
//   chr_r_nw_in    PPU read/write (1 = read)
//   chr_d_in       PPU write data
//   chr_d_out      CHR read data to PPU (zero in the nametable half)
//   chr_mem_addr   banked CHR BRAM address
//   chr_mem_q      CHR BRAM data
//   chr_mem_d      CHR-RAM write data
//   chr_mem_we     CHR-RAM write enable (always 0 for CHR ROM)
//   ciram_nce_out  CIRAM enable, active low
//   ciram_a10_out  CIRAM A10 (mirroring)
// ---------------------------------------------------------------------------
module cart_mmc1 #(
    parameter int PRG_BANKS_LOG2 = 3,
    parameter int CHR_BANKS_LOG2 = 5,
    parameter bit CHR_RAM        = 1'b0
) (
    input  logic                        clk_sys,
    input  logic                        rst,
    output logic                        rst_out,
    input  logic                        prg_nce_in,
    input  logic [14:0]                 prg_a_in,
    input  logic                        prg_r_nw_in,
    input  logic [7:0]                  prg_d_in,
    output logic [7:0]                  prg_d_out,
    output logic [14+PRG_BANKS_LOG2-1:0] prg_rom_addr,
    input  logic [7:0]                  prg_rom_q,
    input  logic [13:0]                 chr_a_in,
    input  logic                        chr_r_nw_in,
    input  logic [7:0]                  chr_d_in,
    output logic [7:0]                  chr_d_out,
    output logic [12+CHR_BANKS_LOG2-1:0] chr_mem_addr,
    input  logic [7:0]                  chr_mem_q,
    output logic [7:0]                  chr_mem_d,
    output logic                        chr_mem_we,
    output logic                        ciram_nce_out,
    output logic                        ciram_a10_out
);

    logic       wr_q;
    logic [2:0] cnt_q,     cnt_d;
    logic [4:0] shift_q,   shift_d;
    logic [4:0] control_q, control_d;
    logic [4:0] chr0_q,    chr0_d;
    logic [4:0] chr1_q,    chr1_d;
    logic [4:0] prg_q,     prg_d;

    logic       wr_now_s;
    logic       wr_pulse_s;
    logic [4:0] shift_full_s;
    logic [3:0] prg_bank_s;
    logic [4:0] chr_bank_s;

    // One pulse per CPU write, however long the strobe is held.
    assign wr_now_s     = ~prg_nce_in & ~prg_r_nw_in;
    assign wr_pulse_s   = wr_now_s & ~wr_q;
    // Value that the fifth write commits: the new bit on top of the four already shifted in.
    assign shift_full_s = {prg_d_in[0], shift_q[4:1]};

    // Serial loader and bank register next-state.
    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        control_d = control_q;
        chr0_d    = chr0_q;
        chr1_d    = chr1_q;
        prg_d     = prg_q;
        if (wr_pulse_s) begin
            if (prg_d_in[7]) begin
                cnt_d          = 3'd0;
                shift_d        = 5'd0;
                control_d[3:2] = 2'b11;
            end else if (cnt_q != 3'd4) begin
                shift_d = shift_full_s;
                cnt_d   = cnt_q + 3'd1;
            end else begin
                cnt_d   = 3'd0;
                shift_d = 5'd0;
                // Only the address of the fifth write selects the target register.
                case (prg_a_in[14:13])
                    2'd0:    control_d = shift_full_s;
                    2'd1:    chr0_d    = shift_full_s;
                    2'd2:    chr1_d    = shift_full_s;
                    2'd3:    prg_d     = shift_full_s;
                    default: prg_d     = prg_q;
                endcase
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers. Reset takes priority over a coincident write.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            wr_q      <= 1'b0;
            cnt_q     <= 3'd0;
            shift_q   <= 5'd0;
            control_q <= 5'b01100;
            chr0_q    <= 5'd0;
            chr1_q    <= 5'd0;
            prg_q     <= 5'd0;
        end else begin
            wr_q      <= wr_now_s;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            control_q <= control_d;
            chr0_q    <= chr0_d;
            chr1_q    <= chr1_d;
            prg_q     <= prg_d;
        end
    end

    // PRG bank selection. prg[4] is unused; the bank is truncated to the ROM size.
    always_comb begin
        prg_bank_s = 4'h0;
        case (control_q[3:2])
            2'b00, 2'b01: prg_bank_s = {prg_q[3:1], prg_a_in[14]};
            2'b10:        prg_bank_s = prg_a_in[14] ? prg_q[3:0] : 4'h0;
            2'b11:        prg_bank_s = prg_a_in[14] ? 4'hF : prg_q[3:0];
            default:      prg_bank_s = 4'h0;
        endcase
    end

    // CHR bank selection: one 8K bank (chr0 with LSB replaced by A12), or two 4K banks.
    always_comb begin
        chr_bank_s = 5'd0;
        if (control_q[4]) begin
            chr_bank_s = chr_a_in[12] ? chr1_q : chr0_q;
        end else begin
            chr_bank_s = {chr0_q[4:1], chr_a_in[12]};
        end
    end

    // Nametable mirroring.
    always_comb begin
        ciram_a10_out = 1'b0;
        case (control_q[1:0])
            2'd0:    ciram_a10_out = 1'b0;
            2'd1:    ciram_a10_out = 1'b1;
            2'd2:    ciram_a10_out = chr_a_in[10];
            2'd3:    ciram_a10_out = chr_a_in[11];
            default: ciram_a10_out = 1'b0;
        endcase
    end

    assign prg_rom_addr  = {prg_bank_s[PRG_BANKS_LOG2-1:0], prg_a_in[13:0]};
    assign chr_mem_addr  = {chr_bank_s[CHR_BANKS_LOG2-1:0], chr_a_in[11:0]};
    assign prg_d_out     = prg_rom_q & {8{~prg_nce_in}};
    assign chr_d_out     = chr_mem_q & {8{~chr_a_in[13]}};
    assign chr_mem_d     = chr_d_in;
    assign chr_mem_we    = CHR_RAM ? (~chr_a_in[13] & ~chr_r_nw_in) : 1'b0;
    assign ciram_nce_out = ~chr_a_in[13];
    assign rst_out       = rst;

endmodule

// File: tb/tb_cart_mmc1.sv
module tb_cart_mmc1;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        prg_nce_in = 1'b1;
    logic [14:0] prg_a_in = 15'h0;
    logic        prg_r_nw_in = 1'b1;
    logic [7:0]  prg_d_in = 8'h00;
    logic [7:0]  prg_rom_q = 8'hA5;
    logic [13:0] chr_a_in = 14'h0;
    logic        chr_r_nw_in = 1'b1;
    logic [7:0]  chr_d_in = 8'h00;
    logic [7:0]  chr_mem_q = 8'h5A;

    logic        rst_out, rst_out_r;
    logic [7:0]  prg_d_out, prg_d_out_r;
    logic [16:0] prg_rom_addr, prg_rom_addr_r;
    logic [7:0]  chr_d_out, chr_d_out_r;
    logic [16:0] chr_mem_addr, chr_mem_addr_r;
    logic [7:0]  chr_mem_d, chr_mem_d_r;
    logic        chr_mem_we, chr_mem_we_r;
    logic        ciram_nce_out, ciram_nce_out_r;
    logic        ciram_a10_out, ciram_a10_out_r;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk_sys = ~clk_sys;

    cart_mmc1 #(.PRG_BANKS_LOG2(3), .CHR_BANKS_LOG2(5), .CHR_RAM(1'b1)) dut (
        .clk_sys(clk_sys), .rst(rst), .rst_out(rst_out),
        .prg_nce_in(prg_nce_in), .prg_a_in(prg_a_in), .prg_r_nw_in(prg_r_nw_in),
        .prg_d_in(prg_d_in), .prg_d_out(prg_d_out), .prg_rom_addr(prg_rom_addr),
        .prg_rom_q(prg_rom_q), .chr_a_in(chr_a_in), .chr_r_nw_in(chr_r_nw_in),
        .chr_d_in(chr_d_in), .chr_d_out(chr_d_out), .chr_mem_addr(chr_mem_addr),
        .chr_mem_q(chr_mem_q), .chr_mem_d(chr_mem_d), .chr_mem_we(chr_mem_we),
        .ciram_nce_out(ciram_nce_out), .ciram_a10_out(ciram_a10_out)
    );

    cart_mmc1 #(.PRG_BANKS_LOG2(3), .CHR_BANKS_LOG2(5), .CHR_RAM(1'b0)) dut_rom (
        .clk_sys(clk_sys), .rst(rst), .rst_out(rst_out_r),
        .prg_nce_in(prg_nce_in), .prg_a_in(prg_a_in), .prg_r_nw_in(prg_r_nw_in),
        .prg_d_in(prg_d_in), .prg_d_out(prg_d_out_r), .prg_rom_addr(prg_rom_addr_r),
        .prg_rom_q(prg_rom_q), .chr_a_in(chr_a_in), .chr_r_nw_in(chr_r_nw_in),
        .chr_d_in(chr_d_in), .chr_d_out(chr_d_out_r), .chr_mem_addr(chr_mem_addr_r),
        .chr_mem_q(chr_mem_q), .chr_mem_d(chr_mem_d_r), .chr_mem_we(chr_mem_we_r),
        .ciram_nce_out(ciram_nce_out_r), .ciram_a10_out(ciram_a10_out_r)
    );

    // One CPU write with the strobe held for 'hold' clocks, then an idle clock.
    task automatic cpu_write(input logic [14:0] a, input logic [7:0] d, input int hold);
        @(negedge clk_sys);
        prg_a_in = a; prg_d_in = d; prg_nce_in = 1'b0; prg_r_nw_in = 1'b0;
        repeat (hold) @(negedge clk_sys);
        prg_nce_in = 1'b1; prg_r_nw_in = 1'b1;
        @(negedge clk_sys);
    endtask

    // Five serial writes, LSB first.
    task automatic write_serial(input logic [14:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) cpu_write(a, {7'h00, v[i]}, 1);
    endtask

    // Present a CPU read address and let the combinational outputs settle.
    task automatic prg_read(input logic [14:0] a);
        @(negedge clk_sys);
        prg_a_in = a; prg_nce_in = 1'b0; prg_r_nw_in = 1'b1;
        #1;
    endtask

    task automatic ppu_addr(input logic [13:0] a, input logic rnw);
        @(negedge clk_sys);
        chr_a_in = a; chr_r_nw_in = rnw;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk_sys); rst = 1'b1; #1;
        n_vec++; if (rst_out !== 1'b1) begin n_miss++; $display("FAIL rst_out_hi: got %b want 1", rst_out); end
        @(negedge clk_sys); rst = 1'b0; #1;
        n_vec++; if (rst_out !== 1'b0) begin n_miss++; $display("FAIL rst_out_lo: got %b want 0", rst_out); end
        prg_read(15'h7FFC);
        n_vec++; if (prg_rom_addr !== 17'h1FFFC) begin n_miss++; $display("FAIL reset_vec_addr: got %h want 1fffc", prg_rom_addr); end
        n_vec++; if (prg_d_out !== 8'hA5) begin n_miss++; $display("FAIL prg_d_sel: got %h want a5", prg_d_out); end
        prg_read(15'h0000);
        n_vec++; if (prg_rom_addr !== 17'h00000) begin n_miss++; $display("FAIL reset_lo_bank: got %h want 00000", prg_rom_addr); end
        ppu_addr(14'h0C00, 1'b1);
        n_vec++; if (ciram_a10_out !== 1'b0) begin n_miss++; $display("FAIL reset_a10: got %b want 0", ciram_a10_out); end
        ppu_addr(14'h1234, 1'b1);
        n_vec++; if (chr_mem_addr !== 17'h01234) begin n_miss++; $display("FAIL reset_chr: got %h want 01234", chr_mem_addr); end
        @(negedge clk_sys); prg_nce_in = 1'b1; #1;
        n_vec++; if (prg_d_out !== 8'h00) begin n_miss++; $display("FAIL prg_d_desel: got %h want 00", prg_d_out); end
    endtask

    task automatic test_prg_load;
        write_serial(15'h6000, 5'd6);
        prg_read(15'h0000);
        n_vec++; if (prg_rom_addr !== 17'h18000) begin n_miss++; $display("FAIL prg6_8000: got %h want 18000", prg_rom_addr); end
        prg_read(15'h4000);
        n_vec++; if (prg_rom_addr !== 17'h1C000) begin n_miss++; $display("FAIL prg6_c000: got %h want 1c000", prg_rom_addr); end
    endtask

    task automatic test_control_32k;
        write_serial(15'h0000, 5'h13);
        prg_read(15'h0000);
        n_vec++; if (prg_rom_addr !== 17'h18000) begin n_miss++; $display("FAIL m32k_lo: got %h want 18000", prg_rom_addr); end
        prg_read(15'h4123);
        n_vec++; if (prg_rom_addr !== 17'h1C123) begin n_miss++; $display("FAIL m32k_hi: got %h want 1c123", prg_rom_addr); end
        ppu_addr(14'h0800, 1'b1);
        n_vec++; if (ciram_a10_out !== 1'b1) begin n_miss++; $display("FAIL horiz_a11: got %b want 1", ciram_a10_out); end
        ppu_addr(14'h0400, 1'b1);
        n_vec++; if (ciram_a10_out !== 1'b0) begin n_miss++; $display("FAIL horiz_a10: got %b want 0", ciram_a10_out); end
    endtask

    task automatic test_reset_bit;
        cpu_write(15'h2000, 8'h01, 1);
        cpu_write(15'h2000, 8'h00, 1);
        cpu_write(15'h2000, 8'h01, 1);
        cpu_write(15'h2000, 8'h80, 1);
        // control now 0x1F: PRG mode 3, mirroring kept at horizontal
        ppu_addr(14'h0800, 1'b1);
        n_vec++; if (ciram_a10_out !== 1'b1) begin n_miss++; $display("FAIL rbit_mirror: got %b want 1", ciram_a10_out); end
        write_serial(15'h6000, 5'd3);
        prg_read(15'h0000);
        n_vec++; if (prg_rom_addr !== 17'h0C000) begin n_miss++; $display("FAIL rbit_lo: got %h want 0c000", prg_rom_addr); end
        prg_read(15'h4000);
        n_vec++; if (prg_rom_addr !== 17'h1C000) begin n_miss++; $display("FAIL rbit_hi: got %h want 1c000", prg_rom_addr); end
    endtask

    task automatic test_chr_vertical;
        write_serial(15'h0000, 5'h12);
        write_serial(15'h4000, 5'd5);
        ppu_addr(14'h1010, 1'b1);
        n_vec++; if (chr_mem_addr !== 17'h05010) begin n_miss++; $display("FAIL chr1_bank: got %h want 05010", chr_mem_addr); end
        ppu_addr(14'h0010, 1'b1);
        n_vec++; if (chr_mem_addr !== 17'h00010) begin n_miss++; $display("FAIL chr0_bank: got %h want 00010", chr_mem_addr); end
        ppu_addr(14'h0400, 1'b1);
        n_vec++; if (ciram_a10_out !== 1'b1) begin n_miss++; $display("FAIL vert_a10: got %b want 1", ciram_a10_out); end
        ppu_addr(14'h0800, 1'b1);
        n_vec++; if (ciram_a10_out !== 1'b0) begin n_miss++; $display("FAIL vert_a11: got %b want 0", ciram_a10_out); end
        prg_read(15'h0000);
        n_vec++; if (prg_rom_addr !== 17'h08000) begin n_miss++; $display("FAIL m0_lo: got %h want 08000", prg_rom_addr); end
        prg_read(15'h4000);
        n_vec++; if (prg_rom_addr !== 17'h0C000) begin n_miss++; $display("FAIL m0_hi: got %h want 0c000", prg_rom_addr); end
        // control 0x19: PRG mode 2, single-screen upper
        write_serial(15'h0000, 5'h19);
        prg_read(15'h0000);
        n_vec++; if (prg_rom_addr !== 17'h00000) begin n_miss++; $display("FAIL m2_lo: got %h want 00000", prg_rom_addr); end
        prg_read(15'h4000);
        n_vec++; if (prg_rom_addr !== 17'h0C000) begin n_miss++; $display("FAIL m2_hi: got %h want 0c000", prg_rom_addr); end
        ppu_addr(14'h0000, 1'b1);
        n_vec++; if (ciram_a10_out !== 1'b1) begin n_miss++; $display("FAIL single_hi: got %b want 1", ciram_a10_out); end
    endtask

    task automatic test_chr_8k;
        write_serial(15'h2000, 5'd3);
        write_serial(15'h0000, 5'h08);
        ppu_addr(14'h0010, 1'b1);
        n_vec++; if (chr_mem_addr !== 17'h02010) begin n_miss++; $display("FAIL chr8k_lo: got %h want 02010", chr_mem_addr); end
        ppu_addr(14'h1010, 1'b1);
        n_vec++; if (chr_mem_addr !== 17'h03010) begin n_miss++; $display("FAIL chr8k_hi: got %h want 03010", chr_mem_addr); end
        ppu_addr(14'h0C00, 1'b1);
        n_vec++; if (ciram_a10_out !== 1'b0) begin n_miss++; $display("FAIL single_lo: got %b want 0", ciram_a10_out); end
    endtask

    task automatic test_long_strobe;
        cpu_write(15'h6000, 8'h01, 6);
        for (int i = 0; i < 4; i++) cpu_write(15'h6000, 8'h00, 1);
        prg_read(15'h4000);
        n_vec++; if (prg_rom_addr !== 17'h04000) begin n_miss++; $display("FAIL long_strobe: got %h want 04000", prg_rom_addr); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) cpu_write(15'h6000, 8'h01, 1);
        @(negedge clk_sys);
        prg_a_in = 15'h6000; prg_d_in = 8'h01; prg_nce_in = 1'b0; prg_r_nw_in = 1'b0; rst = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0; prg_nce_in = 1'b1; prg_r_nw_in = 1'b1;
        prg_read(15'h7FFC);
        n_vec++; if (prg_rom_addr !== 17'h1FFFC) begin n_miss++; $display("FAIL rmid_vec: got %h want 1fffc", prg_rom_addr); end
        prg_read(15'h0000);
        n_vec++; if (prg_rom_addr !== 17'h00000) begin n_miss++; $display("FAIL rmid_prg: got %h want 00000", prg_rom_addr); end
        ppu_addr(14'h1234, 1'b1);
        n_vec++; if (chr_mem_addr !== 17'h01234) begin n_miss++; $display("FAIL rmid_chr: got %h want 01234", chr_mem_addr); end
        write_serial(15'h6000, 5'd5);
        prg_read(15'h0000);
        n_vec++; if (prg_rom_addr !== 17'h14000) begin n_miss++; $display("FAIL rmid_reload: got %h want 14000", prg_rom_addr); end
    endtask

    task automatic test_chr_ram;
        @(negedge clk_sys); chr_d_in = 8'h3C;
        ppu_addr(14'h0123, 1'b0);
        n_vec++; if (chr_mem_we !== 1'b1) begin n_miss++; $display("FAIL ram_we: got %b want 1", chr_mem_we); end
        n_vec++; if (chr_mem_we_r !== 1'b0) begin n_miss++; $display("FAIL rom_we: got %b want 0", chr_mem_we_r); end
        n_vec++; if (chr_mem_d !== 8'h3C) begin n_miss++; $display("FAIL ram_d: got %h want 3c", chr_mem_d); end
        n_vec++; if (ciram_nce_out !== 1'b1) begin n_miss++; $display("FAIL ciram_off: got %b want 1", ciram_nce_out); end
        n_vec++; if (chr_d_out !== 8'h5A) begin n_miss++; $display("FAIL chr_d_pat: got %h want 5a", chr_d_out); end
        ppu_addr(14'h2123, 1'b0);
        n_vec++; if (chr_mem_we !== 1'b0) begin n_miss++; $display("FAIL nt_we: got %b want 0", chr_mem_we); end
        n_vec++; if (ciram_nce_out !== 1'b0) begin n_miss++; $display("FAIL ciram_on: got %b want 0", ciram_nce_out); end
        n_vec++; if (chr_d_out !== 8'h00) begin n_miss++; $display("FAIL chr_d_nt: got %h want 00", chr_d_out); end
        ppu_addr(14'h0123, 1'b1);
        n_vec++; if (chr_mem_we !== 1'b0) begin n_miss++; $display("FAIL read_we: got %b want 0", chr_mem_we); end
    endtask

    initial begin
        repeat (3) @(negedge clk_sys);
        test_reset();
        test_prg_load();
        test_control_32k();
        test_reset_bit();
        test_chr_vertical();
        test_chr_8k();
        test_long_strobe();
        test_reset_mid();
        test_chr_ram();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
